// File: rtl/dma_io_pkg.sv
// Shared types for the DMA I/O peripheral: FSM state and transfer direction.
package dma_io_pkg;

  localparam int BUS_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } dma_io_state_t;

  typedef enum logic {
    D2M = 1'b0,
    M2D = 1'b1
  } dma_io_dir_t;

endpackage

// File: rtl/dma_io_fifo.sv
// Synchronous FIFO, power-of-2 depth; a pop is honoured before a push so a
// push while full succeeds when a pop happens in the same cycle.
module dma_io_fifo #(
  parameter int DEPTH   = 8,
  parameter int W       = 8,
  parameter int CHANNEL = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(pop_i && empty_o))
        else $error("dma_io ch%0d: pop on empty FIFO ignored", CHANNEL);
      assert (!(push_i && full_o && !pop_ok))
        else $error("dma_io ch%0d: push on full FIFO ignored", CHANNEL);
    end
  end
`endif

endmodule

// File: rtl/dma_io_peripheral.sv
// 8237A-side I/O responder: FIFO-buffered, Dreq/Dack/nIOR/nIOW handshake.
// Define DMA_IO_EOP_GEN_EN to tag bytes with loc_last and drive nEOP after the tagged pop.
module dma_io_peripheral
  import dma_io_pkg::*;
#(
  parameter int CHANNEL = 0,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = BUS_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dack_i,
  input  logic              nior_i,
  input  logic              niow_i,
  inout  wire               neop_io,
  inout  wire  [DATA_W-1:0] data_io,
  output logic              dreq_o,
  input  logic              dir_i,
  input  logic              loc_valid_i,
  input  logic [DATA_W-1:0] loc_data_i,
`ifdef DMA_IO_EOP_GEN_EN
  input  logic              loc_last_i,
`endif
  output logic              loc_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              done_o
);

`ifdef DMA_IO_EOP_GEN_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  dma_io_state_t     state_q, state_d;
  dma_io_dir_t       dir;
  logic              nior_q, niow_q;
  logic              nior_rise, niow_rise;
  logic              in_xfer, bus_pop, bus_push;
  logic              xfer_ok, eop_low, data_oe;
  logic [DATA_W-1:0] data_cap_q;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_wdata, fifo_rdata;
  logic [CW-1:0]     fifo_count;

  assign dir       = dma_io_dir_t'(dir_i);
  assign nior_rise = ~nior_q & nior_i;
  assign niow_rise = ~niow_q & niow_i;
  assign in_xfer   = (state_q == XFER);
  assign bus_pop   = in_xfer & dack_i & (dir == D2M) & nior_rise;
  assign bus_push  = in_xfer & dack_i & (dir == M2D) & niow_rise;
  assign xfer_ok   = ((dir == D2M) & ~fifo_empty) | ((dir == M2D) & ~fifo_full);

  assign fifo_push = (dir == D2M) ? loc_valid_i : bus_push;
  assign fifo_pop  = (dir == D2M) ? bus_pop : out_ready_i;
`ifdef DMA_IO_EOP_GEN_EN
  assign fifo_wdata = (dir == D2M) ? {loc_last_i, loc_data_i} : {1'b0, data_cap_q};
`else
  assign fifo_wdata = (dir == D2M) ? loc_data_i : data_cap_q;
`endif

  dma_io_fifo #(.DEPTH(DEPTH), .W(FW), .CHANNEL(CHANNEL)) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_rdata),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign loc_ready_o = (dir == D2M) & ~fifo_full;
  assign out_valid_o = (dir == M2D) & ~fifo_empty;
  assign out_data_o  = fifo_rdata[DATA_W-1:0];

  // Gating with rst_ni releases the bus in the same cycle reset is applied.
  assign data_oe = rst_ni & in_xfer & dack_i & ~nior_i & (dir == D2M);
  assign data_io = data_oe ? fifo_rdata[DATA_W-1:0] : {DATA_W{1'bz}};

`ifdef DMA_IO_EOP_GEN_EN
  logic eop_drv_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) eop_drv_q <= 1'b0;
    else         eop_drv_q <= bus_pop & ~fifo_empty & fifo_rdata[DATA_W];
  end

  assign neop_io = (rst_ni & eop_drv_q) ? 1'b0 : 1'bz;
  assign eop_low = ~neop_io | eop_drv_q;
`else
  assign eop_low = ~neop_io;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      nior_q     <= 1'b1;
      niow_q     <= 1'b1;
      data_cap_q <= '0;
    end else begin
      state_q <= state_d;
      nior_q  <= nior_i;
      niow_q  <= niow_i;
      if (dack_i && !niow_i && dir == M2D) data_cap_q <= data_io;
    end
  end

  always_comb begin
    state_d = state_q;
    dreq_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      IDLE: if (xfer_ok) state_d = REQ;
      REQ: begin
        dreq_o = xfer_ok;
        if (!xfer_ok)    state_d = IDLE;
        else if (dack_i) state_d = XFER;
      end
      XFER: begin
        dreq_o = xfer_ok;
        if (eop_low)     state_d = DONE;
        else if (!dack_i) state_d = IDLE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (fifo_count <= CW'(DEPTH))
        else $error("dma_io ch%0d: FIFO count overflow", CHANNEL);
    end
  end
`endif

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Directed bench for dma_io_peripheral: D2M, M2D, full overlap, nEOP, reset abort.
module tb_dma_io_peripheral;
  import dma_io_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, dack, nior, niow, dir, loc_valid, out_ready;
  logic       tb_eop, tb_data_oe, loc_last;
  logic [7:0] loc_data, tb_data, out_data;
  logic       dreq, loc_ready, out_valid, done;
  wire        neop;
  wire  [7:0] data_bus;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pullup (neop);
  assign neop     = tb_eop ? 1'b0 : 1'bz;
  assign data_bus = tb_data_oe ? tb_data : 8'hzz;

  dma_io_peripheral #(.CHANNEL(0), .DEPTH(8), .DATA_W(8)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dack_i      (dack),
    .nior_i      (nior),
    .niow_i      (niow),
    .neop_io     (neop),
    .data_io     (data_bus),
    .dreq_o      (dreq),
    .dir_i       (dir),
    .loc_valid_i (loc_valid),
    .loc_data_i  (loc_data),
`ifdef DMA_IO_EOP_GEN_EN
    .loc_last_i  (loc_last),
`endif
    .loc_ready_o (loc_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (out_ready),
    .done_o      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
      else begin
        errs++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [7:0] exp);
    nior = 1'b0;
    #1;
    chk("rd_oe", 32'(dut.data_oe), 32'd1);
    chk("rd_data", 32'(data_bus), 32'(exp));
    @(negedge clk);
    nior = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [7:0] v);
    tb_data    = v;
    tb_data_oe = 1'b1;
    niow       = 1'b0;
    @(negedge clk);
    niow = 1'b1;
    @(negedge clk);
  endtask

  task automatic loc_push(input logic [7:0] v, input logic last);
    loc_data  = v;
    loc_last  = last;
    loc_valid = 1'b1;
    @(negedge clk);
    loc_valid = 1'b0;
    loc_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dack = 1'b0; nior = 1'b1; niow = 1'b1; dir = 1'b0;
    loc_valid = 1'b0; loc_data = 8'h00; loc_last = 1'b0; out_ready = 1'b0;
    tb_eop = 1'b0; tb_data_oe = 1'b0; tb_data = 8'h00;
    cyc(3);

    // reset state
    chk("rst_dreq", 32'(dreq), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(dut.u_fifo.count_o), 32'd0);
    chk("rst_loc_ready", 32'(loc_ready), 32'd1);
    chk("rst_oe", 32'(dut.data_oe), 32'd0);
    rst_n = 1'b1;
    cyc(1);

    // 1: D2M
    loc_data = 8'hA5; loc_valid = 1'b1;
    cyc(1);
    chk("d2m_dreq_pre", 32'(dreq), 32'd0);
    loc_data = 8'h3C;
    cyc(1);
    loc_valid = 1'b0;
    chk("d2m_dreq", 32'(dreq), 32'd1);
    chk("d2m_count", 32'(dut.u_fifo.count_o), 32'd2);
    dack = 1'b1;
    cyc(1);
    bus_read(8'hA5);
    chk("d2m_dreq_mid", 32'(dreq), 32'd1);
    bus_read(8'h3C);
    chk("d2m_dreq_end", 32'(dreq), 32'd0);
    chk("d2m_empty", 32'(dut.u_fifo.count_o), 32'd0);
    dack = 1'b0;
    cyc(2);

    // 2: M2D
    dir = 1'b1;
    cyc(1);
    chk("m2d_dreq", 32'(dreq), 32'd1);
    chk("m2d_valid0", 32'(out_valid), 32'd0);
    dack = 1'b1;
    cyc(1);
    bus_write(8'h11);
    chk("m2d_valid1", 32'(out_valid), 32'd1);
    chk("m2d_head1", 32'(out_data), 32'h11);
    bus_write(8'h22);
    chk("m2d_head_keep", 32'(out_data), 32'h11);
    out_ready = 1'b1;
    cyc(1);
    chk("m2d_head2", 32'(out_data), 32'h22);
    cyc(1);
    out_ready = 1'b0;
    chk("m2d_drained", 32'(out_valid), 32'd0);

    // 3: fill to full, then overlapped pop/push
    for (int i = 0; i < 8; i++) bus_write(8'h40 + 8'(i));
    chk("full_count", 32'(dut.u_fifo.count_o), 32'd8);
    chk("full_dreq", 32'(dreq), 32'd0);
    tb_data = 8'h48;
    niow = 1'b0;
    cyc(1);
    niow = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    out_ready = 1'b0;
    chk("ovl_count", 32'(dut.u_fifo.count_o), 32'd8);
    chk("ovl_head", 32'(out_data), 32'h41);
    for (int i = 0; i < 8; i++) begin
      chk("ovl_drain", 32'(out_data), 32'h41 + 32'(i));
      out_ready = 1'b1;
      cyc(1);
    end
    out_ready = 1'b0;
    chk("ovl_empty", 32'(out_valid), 32'd0);

    // 4: external nEOP termination
    tb_data_oe = 1'b0;
    tb_eop = 1'b1;
    cyc(1);
    tb_eop = 1'b0;
    chk("eop_done", 32'(done), 32'd1);
    chk("eop_dreq", 32'(dreq), 32'd0);
    dack = 1'b0;
    dir  = 1'b0;
    cyc(1);
    chk("eop_done_off", 32'(done), 32'd0);
    chk("eop_state", 32'(dut.state_q), 32'(IDLE));

    // 5: reset during D2M read
    loc_push(8'h5A, 1'b0);
    loc_push(8'h6B, 1'b0);
    dack = 1'b1;
    cyc(2);
    nior = 1'b0;
    #1;
    chk("abort_oe_pre", 32'(dut.data_oe), 32'd1);
    chk("abort_data_pre", 32'(data_bus), 32'h5A);
    rst_n = 1'b0;
    #1;
    chk("abort_oe_now", 32'(dut.data_oe), 32'd0);
    cyc(1);
    chk("abort_dreq", 32'(dreq), 32'd0);
    chk("abort_count", 32'(dut.u_fifo.count_o), 32'd0);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    nior = 1'b1;
    dack = 1'b0;
    rst_n = 1'b1;
    cyc(1);

    // strobes without Dack do nothing
    loc_push(8'h77, 1'b0);
    nior = 1'b0;
    cyc(1);
    nior = 1'b1;
    cyc(2);
    chk("nodack_count", 32'(dut.u_fifo.count_o), 32'd1);

`ifdef DMA_IO_EOP_GEN_EN
    // 6: generated nEOP on the tagged byte
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    loc_push(8'h01, 1'b0);
    loc_push(8'h02, 1'b0);
    loc_push(8'h03, 1'b1);
    dack = 1'b1;
    cyc(2);
    bus_read(8'h01);
    chk("gen_neop_idle", 32'(neop), 32'd1);
    bus_read(8'h02);
    bus_read(8'h03);
    chk("gen_neop_low", 32'(neop), 32'd0);
    cyc(1);
    chk("gen_done", 32'(done), 32'd1);
    chk("gen_neop_rel", 32'(neop), 32'd1);
    dack = 1'b0;
    cyc(1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
